hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage (IF/ID/EX/MEM/WB) processor. It keeps a shadow record of the destination registers of the instructions now in EX and MEM. From that record it sequences the pipeline: load-use stalls, taken-branch flushes and whole-pipeline freezes on data-memory wait. It also produces registered forwarding-mux selects for the two ALU operands, so they are aligned with the consumer's EX cycle.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/hazard_match.sv | 16 +
 rtl/hazard_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// shadow-slot record and the per-cycle pipeline action.
package pipe_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       is_load;
  } shadow_slot_t;

  localparam shadow_slot_t BUBBLE = '{rd: 5'd0, wr: 1'b0, is_load: 1'b0};

  typedef enum logic [1:0] {
    ACT_FREEZE,
    ACT_FLUSH,
    ACT_STALL,
    ACT_RUN
  } pipe_act_t;

  // EX/MEM wins over MEM/WB because it holds the younger result.
  function automatic fwd_sel_t fwd_pick(input logic hit_ex, input logic hit_mem);
    if (hit_ex)       return FWD_EXMEM;
    else if (hit_mem) return FWD_MEMWB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source register against one shadow slot; XZR never matches.
module hazard_match
  import pipe_pkg::*;
(
  input  logic [4:0]   src,
  input  logic         used,
  input  shadow_slot_t slot,
  output logic         match
);

  logic unused_is_load;
  assign unused_is_load = slot.is_load;

  assign match = used && slot.wr && (slot.rd == src) && (src != XZR);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait
// freezes and registered forwarding selects for the two ALU operands.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rmd,
  input  logic             id_rn_used,
  input  logic             id_rmd_used,
  input  logic [4:0]       id_rd,
  input  logic             id_wr,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  shadow_slot_t     ex_q, mem_q, id_slot;
  fwd_sel_t         fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rn_ex, rmd_ex, rn_mem, rmd_mem;
  logic             load_use;
  pipe_act_t        act;

  assign id_slot = '{rd: id_rd, wr: id_wr, is_load: id_is_load};

  hazard_match u_rn_ex   (.src(id_rn),  .used(id_rn_used),  .slot(ex_q),  .match(rn_ex));
  hazard_match u_rmd_ex  (.src(id_rmd), .used(id_rmd_used), .slot(ex_q),  .match(rmd_ex));
  hazard_match u_rn_mem  (.src(id_rn),  .used(id_rn_used),  .slot(mem_q), .match(rn_mem));
  hazard_match u_rmd_mem (.src(id_rmd), .used(id_rmd_used), .slot(mem_q), .match(rmd_mem));

  assign load_use = id_valid && (rn_ex || rmd_ex) && ex_q.is_load;

  always_comb begin
    act = ACT_RUN;
    if (mem_stall)            act = ACT_FREEZE;
    else if (ex_branch_taken) act = ACT_FLUSH;
    else if (load_use)        act = ACT_STALL;
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    pipe_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      pipe_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (act)
        ACT_FREEZE: begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          pipe_en = 1'b0;
        end
        ACT_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        ACT_STALL: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, so it is
  // sampled inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else if (pipe_en) begin
      mem_q <= ex_q;
      if (id_valid && !idex_bubble) begin
        ex_q    <= id_slot;
        fwd_a_q <= fwd_pick(rn_ex, rn_mem);
        fwd_b_q <= fwd_pick(rmd_ex, rmd_mem);
      end else begin
        ex_q    <= BUBBLE;
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end
      if (act == ACT_STALL && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl with a narrow stall counter
// so saturation is reachable in a short run.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  // Control expectation packed as {pc_en, ifid_en, pipe_en, ifid_flush, idex_bubble}
  localparam logic [4:0] C_RUN   = 5'b11100;
  localparam logic [4:0] C_STALL = 5'b00101;
  localparam logic [4:0] C_FLUSH = 5'b11111;
  localparam logic [4:0] C_FRZ   = 5'b00000;
  localparam logic [4:0] C_RST   = 5'b00011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rn;
    logic       rn_used;
    logic [4:0] rmd;
    logic       rmd_used;
    logic [4:0] rd;
    logic       wr;
    logic       is_load;
  } id_t;

  typedef struct packed {
    logic             rst;
    id_t              id;
    logic             br;
    logic             ms;
    logic [4:0]       ctrl;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset, id_valid, id_rn_used, id_rmd_used, id_wr, id_is_load;
  logic [4:0]       id_rn, id_rmd, id_rd;
  logic             ex_branch_taken, mem_stall;
  logic             pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rn(id_rn), .id_rmd(id_rmd),
    .id_rn_used(id_rn_used), .id_rmd_used(id_rmd_used),
    .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_en(pipe_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  function automatic id_t nop();
    return '0;
  endfunction

  function automatic id_t add(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
    id_t i;
    i = '{valid: 1'b1, rn: rn, rn_used: 1'b1, rmd: rm, rmd_used: 1'b1,
          rd: rd, wr: 1'b1, is_load: 1'b0};
    return i;
  endfunction

  function automatic id_t ldur(input logic [4:0] rd, input logic [4:0] rn);
    id_t i;
    i = '{valid: 1'b1, rn: rn, rn_used: 1'b1, rmd: 5'd0, rmd_used: 1'b0,
          rd: rd, wr: 1'b1, is_load: 1'b1};
    return i;
  endfunction

  function automatic vec_t mk(input logic rst, input id_t id, input logic br, input logic ms,
                              input logic [4:0] ctrl, input logic [1:0] fa,
                              input logic [1:0] fb, input int cnt);
    vec_t v;
    v.rst = rst; v.id = id; v.br = br; v.ms = ms; v.ctrl = ctrl;
    v.fa = fa; v.fb = fb; v.cnt = cnt[CNT_W-1:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, check combinational controls, clock it, check registered state.
  task automatic apply(input vec_t v, input string tag);
    reset           = v.rst;
    id_valid        = v.id.valid;
    id_rn           = v.id.rn;
    id_rn_used      = v.id.rn_used;
    id_rmd          = v.id.rmd;
    id_rmd_used     = v.id.rmd_used;
    id_rd           = v.id.rd;
    id_wr           = v.id.wr;
    id_is_load      = v.id.is_load;
    ex_branch_taken = v.br;
    mem_stall       = v.ms;
    #1;
    check({tag, " ctrl"}, {27'd0, pc_en, ifid_en, pipe_en, ifid_flush, idex_bubble},
          {27'd0, v.ctrl});
    @(posedge clk);
    #1;
    check({tag, " fwd_a"}, {30'd0, fwd_a}, {30'd0, v.fa});
    check({tag, " fwd_b"}, {30'd0, fwd_b}, {30'd0, v.fb});
    check({tag, " stall_count"}, {{(32-CNT_W){1'b0}}, stall_count},
          {{(32-CNT_W){1'b0}}, v.cnt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   c;

    vecs.push_back(mk(1, nop(),          0, 0, C_RST,   0, 0, 0));
    vecs.push_back(mk(1, nop(),          0, 0, C_RST,   0, 0, 0));
    vecs.push_back(mk(0, add(1, 2, 3),   0, 0, C_RUN,   0, 0, 0));
    vecs.push_back(mk(0, add(4, 1, 5),   0, 0, C_RUN,   1, 0, 0));
    vecs.push_back(mk(0, add(1, 2, 3),   0, 0, C_RUN,   0, 0, 0));
    vecs.push_back(mk(0, nop(),          0, 0, C_RUN,   0, 0, 0));
    vecs.push_back(mk(0, add(6, 7, 1),   0, 0, C_RUN,   0, 2, 0));
    vecs.push_back(mk(0, ldur(9, 10),    0, 0, C_RUN,   0, 0, 0));
    vecs.push_back(mk(0, add(10, 9, 9),  0, 0, C_STALL, 0, 0, 1));
    vecs.push_back(mk(0, add(10, 9, 9),  0, 0, C_RUN,   2, 2, 1));
    vecs.push_back(mk(0, ldur(31, 10),   0, 0, C_RUN,   1, 0, 1));
    vecs.push_back(mk(0, add(11, 31, 31),0, 0, C_RUN,   0, 0, 1));
    vecs.push_back(mk(0, ldur(12, 2),    0, 0, C_RUN,   0, 0, 1));
    vecs.push_back(mk(0, add(13, 12, 3), 1, 0, C_FLUSH, 0, 0, 1));
    vecs.push_back(mk(0, add(14, 12, 11),0, 0, C_RUN,   2, 0, 1));
    vecs.push_back(mk(0, ldur(16, 14),   0, 0, C_RUN,   1, 0, 1));
    vecs.push_back(mk(0, add(17, 16, 2), 0, 1, C_FRZ,   1, 0, 1));
    vecs.push_back(mk(0, add(17, 16, 2), 0, 1, C_FRZ,   1, 0, 1));
    vecs.push_back(mk(0, add(17, 16, 2), 0, 1, C_FRZ,   1, 0, 1));
    vecs.push_back(mk(0, add(17, 16, 2), 0, 0, C_STALL, 0, 0, 2));
    vecs.push_back(mk(0, add(17, 16, 2), 0, 0, C_RUN,   2, 0, 2));
    vecs.push_back(mk(0, add(18, 17, 17),1, 1, C_FRZ,   2, 0, 2));
    vecs.push_back(mk(0, add(18, 17, 17),1, 0, C_FLUSH, 0, 0, 2));

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Drive the counter up to all-ones, then one stall past it.
    c = 2;
    for (int k = 0; k < 14; k++) begin
      if (c < (1 << CNT_W) - 1) c++;
      apply(mk(0, ldur(20, 2),    0, 0, C_RUN,   0, 0, (k == 0) ? 2 : c - ((c == 15 && k == 13) ? 0 : 1)),
            $sformatf("sat%0d ld", k));
      apply(mk(0, add(21, 20, 2), 0, 0, C_STALL, 0, 0, c), $sformatf("sat%0d use", k));
    end

    // Reset arriving while a load-use stall is pending drops everything.
    apply(mk(0, ldur(20, 2),    0, 0, C_RUN,   0, 0, 15), "rst ld");
    apply(mk(1, add(21, 20, 2), 0, 0, C_RST,   0, 0, 0),  "rst mid");
    apply(mk(0, add(21, 20, 2), 0, 0, C_RUN,   0, 0, 0),  "rst after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
